i2c_bus_arbiter: RTL

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

---
 rtl/i2c_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C pad pair between NUM_REQUESTERS local masters. The bus is
// offered only after it has been seen idle (SCL and SDA both high) for
// IDLE_CYCLES consecutive clocks. The next owner is chosen round-robin,
// starting after the last owner. While a grant is held, the owner's
// open-drain drives are routed straight to the pads.
//
// Optional feature (macro I2C_ARBITER_TIMEOUT_EN):
//   Bounds a grant to TIMEOUT_CYCLES clocks. On expiry the arbiter pulses
//   timeout and locks the owner out until its request is seen low.
//   With the macro undefined, timeout is tied low and grants are unbounded.
//
// Ports:
//   system_clock     in   sole clock, rising edge
//   system_reset_n   in   async active-low reset, deassertion synchronised
//   request[N]       in   per-requester bus request
//   grant[N]         out  registered, one-hot or zero
//   req_scl_output[N], req_sda_output[N]
//                    in   per-requester open-drain drive (1 = release)
//   scl_output, sda_output
//                    out  pad drive (1 = release)
//   scl_input, sda_input
//                    in   asynchronous pad levels
//   busy             out  high while any grant is asserted
//   timeout          out  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDLE_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic                      system_clock,
  input  logic                      system_reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  output logic [NUM_REQUESTERS-1:0] grant,
  input  logic [NUM_REQUESTERS-1:0] req_scl_output,
  input  logic [NUM_REQUESTERS-1:0] req_sda_output,
  output logic                      scl_output,
  output logic                      sda_output,
  input  logic                      scl_input,
  input  logic                      sda_input,
  output logic                      busy,
  output logic                      timeout
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8) begin : g_bad_num
    $error("NUM_REQUESTERS must be in 2..8");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("IDLE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_WAIT_FREE = 2'd0,
    ST_READY     = 2'd1,
    ST_GRANTED   = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  // Reset synchroniser: assertion is immediate, release takes two edges,
  // so the FSM makes its first move no earlier than the third edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Pad level synchronisers; reset to the idle (high) level.
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_bus_free;

  always_ff @(posedge system_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_input};
      r_sda_sync <= {r_sda_sync[0], sda_input};
    end
  end

  assign w_bus_free = r_scl_sync[1] & r_sda_sync[1];

  // Arbitration state
  state_t                    r_state,  w_state_nxt;
  logic [CNT_W-1:0]          r_count,  w_count_nxt;
  logic [IDX_W-1:0]          r_last,   w_last_nxt;
  logic [IDX_W-1:0]          r_winner, w_winner_nxt;
  logic [NUM_REQUESTERS-1:0] r_grant,  w_grant_nxt;
  logic [NUM_REQUESTERS-1:0] w_eligible;
  logic                      w_found;
  logic [IDX_W-1:0]          w_pick;

`ifdef I2C_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [HOLD_W-1:0]         r_hold,    w_hold_nxt;
  logic                      r_timeout, w_timeout_nxt;
  logic [NUM_REQUESTERS-1:0] r_lockout, w_lock_set;

  assign w_eligible = request & ~r_lockout;
`else
  assign w_eligible = request;
`endif

  // Round-robin search starting one past the previous owner.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      v_idx = (int'(r_last) + k) % NUM_REQUESTERS;
      if (!w_found && w_eligible[v_idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_last_nxt   = r_last;
    w_winner_nxt = r_winner;
    w_grant_nxt  = r_grant;
`ifdef I2C_ARBITER_TIMEOUT_EN
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    w_lock_set    = '0;
`endif
    unique case (r_state)
      ST_WAIT_FREE: begin
        if (!w_bus_free) begin
          w_count_nxt = '0;
        end else if (r_count == CNT_W'(IDLE_CYCLES - 1)) begin
          w_count_nxt = '0;
          w_state_nxt = ST_READY;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      ST_READY: begin
        // A foreign master taking the bus wins over any local request.
        if (!w_bus_free) begin
          w_count_nxt = '0;
          w_state_nxt = ST_WAIT_FREE;
        end else if (w_found) begin
          w_winner_nxt         = w_pick;
          w_grant_nxt          = '0;
          w_grant_nxt[w_pick]  = 1'b1;
          w_state_nxt          = ST_GRANTED;
`ifdef I2C_ARBITER_TIMEOUT_EN
          w_hold_nxt           = '0;
`endif
        end
      end
      ST_GRANTED: begin
        // A voluntary drop takes priority over an expiring hold counter.
        if (!request[r_winner]) begin
          w_grant_nxt = '0;
          w_last_nxt  = r_winner;
          w_state_nxt = ST_RELEASE;
        end
`ifdef I2C_ARBITER_TIMEOUT_EN
        else if (r_hold == HOLD_W'(TIMEOUT_CYCLES - 1)) begin
          w_grant_nxt          = '0;
          w_last_nxt           = r_winner;
          w_state_nxt          = ST_RELEASE;
          w_timeout_nxt        = 1'b1;
          w_lock_set[r_winner] = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        w_count_nxt = '0;
        w_state_nxt = ST_WAIT_FREE;
      end
      default: begin
        w_state_nxt = ST_WAIT_FREE;
      end
    endcase
  end

  always_ff @(posedge system_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_WAIT_FREE;
      r_count  <= '0;
      r_last   <= IDX_W'(NUM_REQUESTERS - 1);
      r_winner <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_last   <= w_last_nxt;
      r_winner <= w_winner_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

`ifdef I2C_ARBITER_TIMEOUT_EN
  // Lockout bits clear as soon as the requester is seen with request low.
  always_ff @(posedge system_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
      r_lockout <= '0;
    end else begin
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
      r_lockout <= (r_lockout & request) | w_lock_set;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // Pad mux: only the owner reaches the pads. The raw reset input is ORed
  // in so the pads release at the instant reset asserts; an OR can only
  // pull the output towards 1, so no low glitch is possible.
  logic w_scl_mux;
  logic w_sda_mux;

  always_comb begin
    w_scl_mux = 1'b1;
    w_sda_mux = 1'b1;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (r_grant[i]) begin
        w_scl_mux = req_scl_output[i];
        w_sda_mux = req_sda_output[i];
      end
    end
  end

  assign scl_output = w_scl_mux | ~system_reset_n;
  assign sda_output = w_sda_mux | ~system_reset_n;
  assign grant      = r_grant;
  assign busy       = |r_grant;

endmodule
